be_ram_ctrl: RTL and testbench
==============================

# be_ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request interface, per-byte write enables, a registered read response with back-pressure, and a hardware clear sequencer.
- Replaces the tri-state, combinational-read memory used so far. It is the standard storage block for register files and scratch buffers in the design.
- After reset, or on a `clr` pulse, it writes `INIT_VAL` to every word before accepting traffic.

## Interface
Parameters:
- AWIDTH, 5, address width; depth `D_NUM = 2**AWIDTH`
- DWIDTH, 8, data width; must be a multiple of 8
- BWIDTH, DWIDTH/8, byte-enable width (derived; do not override)
- INIT_VAL, 0, word value written by the clear sequence

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous request to start or restart the clear sequence
- busy  out  1  high while the clear sequence runs
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid&req_ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  AWIDTH  word address
- req_wdata  in  DWIDTH  write data
- req_be  in  BWIDTH  byte enables; bit i covers data[8i+7:8i]
- rsp_valid  out  1  read data present
- rsp_ready  in  1  consumer takes the response on an edge where rsp_valid&rsp_ready
- rsp_rdata  out  DWIDTH  read data

## Operation
FSM states:
- CLEAR
  - Counter `clr_addr` runs from 0 to D_NUM-1. Each cycle writes INIT_VAL (all bytes) to `clr_addr`.
  - After writing D_NUM-1, go to IDLE.
  - `busy`=1 and `req_ready`=0 throughout.
- IDLE
  - Serves requests.
  - `clr`=1 moves to CLEAR with `clr_addr`=0 on the next edge.

Request and response rules:
- `req_ready = (state==IDLE) & ~clr & (~rsp_valid | rsp_ready)`. This is combinational from inputs; `clr` takes priority over a same-cycle request.
- Accepted write: only bytes with `req_be[i]`=1 are updated.
  - `req_be`=0 is a legal no-op.
  - Writes produce no response.
- Accepted read: `rsp_rdata` is loaded with `mem[req_addr]` and `rsp_valid` is set.
  - Both hold stable until the response is taken.
  - A read accepted in the same cycle the previous response is taken reloads the register, so `rsp_valid` stays 1 (full throughput).
- If the response is taken with no new read accepted, `rsp_valid` clears. `rsp_rdata` keeps its last value.
- `clr` in CLEAR restarts the counter at 0.
- `clr` does not affect a pending response; it remains until taken.
- The memory array itself has no reset. Its contents are defined only via the clear sequence.

## Timing
Reset (rst_n low, asynchronous):
- state=CLEAR, `clr_addr`=0, `busy`=1, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0.
- Reset mid-operation abandons any pending response and restarts the clear.

Latency and ordering:
- Clear takes exactly D_NUM cycles from the first edge after reset release (or after `clr` sampled in IDLE). `req_ready` can first rise in the following cycle.
- Read latency: request accepted at edge N gives `rsp_valid`=1 with data after edge N.
- Write-to-read: a write accepted at edge N is visible to a read accepted at edge N+1.
- Sustained throughput: one request per cycle while `rsp_ready`=1.
- Address wrap: not applicable; every AWIDTH value is in range.

## Structure
- Package `mem_pkg`:
  - state enum `{CLEAR, IDLE}`
  - helper function for BWIDTH
- Sub-module `mem_array`:
  - D_NUM×DWIDTH storage
  - byte-enable synchronous write port
  - combinational read mux
  - no reset
- The top level holds the FSM, the clear counter, the handshake logic and the response register. It drives `mem_array` write inputs from either the clear path or the request path.

## Test plan
Run at AWIDTH=5, DWIDTH=16, INIT_VAL=16'hA5A5.
1. Release reset, then hold rsp_ready=1 and read all 32 addresses.
   - `busy` is high exactly 32 cycles and `req_ready`=0 during that time.
   - Every read returns 16'hA5A5.
2. Write 16'h1234 to addr 3 with be=2'b11, then write 16'hFF00 with be=2'b10, then read addr 3 on the next cycle.
   - `rsp_rdata`=16'hFF34, `rsp_valid` one cycle after acceptance.
3. Issue 4 back-to-back reads with rsp_ready=0 after the first acceptance.
   - `req_ready` drops; the first response is held stable.
   - Raising rsp_ready gives the remaining three in order with no gap.
4. Pulse `clr` in the same cycle as req_valid=1 (write 16'h0001 to addr 7).
   - The request is not accepted.
   - 32-cycle clear runs; addr 7 then reads 16'hA5A5.
5. Assert rst_n=0 mid-burst with a pending response.
   - `rsp_valid` goes to 0 immediately (asynchronously).
   - Clear restarts after release.
6. Pulse `clr` at clr_addr=10 during CLEAR.
   - Clear restarts from 0.
   - `busy` lasts 11+32 cycles in total.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-enable RAM controller.
package mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   function automatic int calc_bwidth(input int dwidth);
      return dwidth / 8;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Storage array: byte-enable synchronous write, combinational read, no reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8,
   parameter int BWIDTH = calc_bwidth(DWIDTH)
) (
   input  logic              clk_i,
   input  logic [BWIDTH-1:0] we_i,
   input  logic [AWIDTH-1:0] waddr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic [AWIDTH-1:0] raddr_i,
   output logic [DWIDTH-1:0] rdata_o
);

   localparam int D_NUM = 2**AWIDTH;

   logic [DWIDTH-1:0] mem_q [D_NUM];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < BWIDTH; b++) begin
         if (we_i[b]) begin
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/be_ram_ctrl.sv
// Single-port RAM with valid/ready requests, byte enables, registered read
// response with back-pressure, and a clear sequencer that fills INIT_VAL.
//
// state | meaning
// CLEAR | writing INIT_VAL to clr_addr each cycle, requests blocked
// IDLE  | serving read/write requests
module be_ram_ctrl
   import mem_pkg::*;
#(
   parameter int                AWIDTH   = 5,
   parameter int                DWIDTH   = 8,
   parameter int                BWIDTH   = calc_bwidth(DWIDTH),
   parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   input  logic [BWIDTH-1:0] req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata
);

   localparam logic [AWIDTH-1:0] CLR_LAST = {AWIDTH{1'b1}};

   state_e            state_q;
   logic [AWIDTH-1:0] clr_addr_q;
   logic              busy_q;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic              req_fire;
   logic              rd_fire;
   logic [BWIDTH-1:0] mem_we;
   logic [AWIDTH-1:0] mem_waddr;
   logic [DWIDTH-1:0] mem_wdata;
   logic [DWIDTH-1:0] mem_rdata;

   // clr wins over a same-cycle request; a held response blocks new requests
   assign req_ready = (state_q == IDLE) & ~clr & (~rsp_valid_q | rsp_ready);
   assign req_fire  = req_valid & req_ready;
   assign rd_fire   = req_fire & ~req_wr;

   always_comb begin
      mem_we    = '0;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
      if (state_q == CLEAR) begin
         mem_we    = '1;
         mem_waddr = clr_addr_q;
         mem_wdata = INIT_VAL;
      end else if (req_fire & req_wr) begin
         mem_we = req_be;
      end
   end

   mem_array #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH),
      .BWIDTH (BWIDTH)
   ) u_mem_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (req_addr),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               if (clr) begin
                  clr_addr_q <= '0;
               end else if (clr_addr_q == CLR_LAST) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  clr_addr_q <= '0;
               end else begin
                  clr_addr_q <= clr_addr_q + AWIDTH'(1);
               end
            end
            IDLE: begin
               if (clr) begin
                  state_q    <= CLEAR;
                  busy_q     <= 1'b1;
                  clr_addr_q <= '0;
               end
            end
            default: begin
               state_q    <= CLEAR;
               busy_q     <= 1'b1;
               clr_addr_q <= '0;
            end
         endcase
      end
   end

   // a read taken and reloaded in the same cycle keeps rsp_valid high
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      if (rd_fire) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = mem_rdata;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_be_ram_ctrl.sv
// Bench for be_ram_ctrl: behavioural model with per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
module tb_be_ram_ctrl;

   localparam int          AW   = 5;
   localparam int          DW   = 16;
   localparam int          DEP  = 32;
   localparam logic [15:0] INIT = 16'hA5A5;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        clr       = 1'b0;
   logic        busy;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr    = 1'b0;
   logic [4:0]  req_addr  = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_be    = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_rdata;

   int n_cmp = 0;
   int n_err = 0;

   be_ram_ctrl #(
      .AWIDTH   (AW),
      .DWIDTH   (DW),
      .INIT_VAL (INIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .busy      (busy),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   // model: remaining clear cycles, byte-level memory, response register
   int          clr_left  = DEP;
   logic        exp_valid = 1'b0;
   logic [15:0] exp_data  = '0;
   logic [7:0]  mdl [DEP][2];

   function automatic logic model_ready();
      return (clr_left == 0) && !clr && (!exp_valid || rsp_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_left  = DEP;
         exp_valid = 1'b0;
         exp_data  = '0;
      end else begin
         logic acc;
         acc = req_valid && model_ready();
         if (clr) begin
            clr_left = DEP;
         end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) begin
               for (int a = 0; a < DEP; a++) begin
                  mdl[a][0] = INIT[7:0];
                  mdl[a][1] = INIT[15:8];
               end
            end
         end
         if (acc && req_wr) begin
            for (int b = 0; b < 2; b++)
               if (req_be[b]) mdl[req_addr][b] = req_wdata[8*b +: 8];
         end
         if (acc && !req_wr) begin
            exp_data  = {mdl[req_addr][1], mdl[req_addr][0]};
            exp_valid = 1'b1;
         end else if (rsp_ready) begin
            exp_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(clr_left > 0));
      check("req_ready", 32'(req_ready), 32'(model_ready()));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic wr, input logic [4:0] a, input logic [15:0] d,
                        input logic [1:0] be);
      logic ok;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      ok        = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL issue_timeout addr=%0d: actual=not_accepted required=accepted", a);
      end
   endtask

   // counts busy cycles; optionally pulses clr so that edge clr_at+1 samples it
   task automatic count_busy(input int clr_at, output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
         if (i == clr_at - 1) begin
            @(posedge clk);
            #1;
            clr = 1'b1;
         end else if (i == clr_at) begin
            @(posedge clk);
            #1;
            clr = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   logic [15:0] vals [4];
   int          cnt;

   initial begin
      vals[0] = 16'hC0DE;
      vals[1] = 16'hBEEF;
      vals[2] = 16'h0F0F;
      vals[3] = 16'h7711;

      #1 rst_n = 1'b0;
      #2;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;

      // 1: clear length, then every word reads INIT
      count_busy(-1, cnt);
      check("t1_busy_len", 32'(cnt), 32'd32);
      for (int a = 0; a < DEP; a++) begin
         issue(1'b0, 5'(a), 16'h0, 2'b00);
         check("t1_rd_valid", 32'(rsp_valid), 32'd1);
         check("t1_rd_data", 32'(rsp_rdata), 32'hA5A5);
      end

      // 2: partial byte write
      issue(1'b1, 5'd3, 16'h1234, 2'b11);
      issue(1'b1, 5'd3, 16'hFF00, 2'b10);
      issue(1'b0, 5'd3, 16'h0, 2'b00);
      check("t2_valid", 32'(rsp_valid), 32'd1);
      check("t2_data", 32'(rsp_rdata), 32'hFF34);

      // 3: back-pressure with a held response, then full-rate drain
      for (int k = 0; k < 4; k++) issue(1'b1, 5'(10 + k), vals[k], 2'b11);
      issue(1'b0, 5'd10, 16'h0, 2'b00);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 5'd11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_ready_low", 32'(req_ready), 32'd0);
         check("t3_hold_data", 32'(rsp_rdata), 32'(vals[0]));
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         req_addr = 5'(10 + k);
         @(posedge clk);
         #1;
         check("t3_stream_valid", 32'(rsp_valid), 32'd1);
         check("t3_stream_data", 32'(rsp_rdata), 32'(vals[k]));
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("t3_drained", 32'(rsp_valid), 32'd0);

      // 4: clr beats a same-cycle write
      clr       = 1'b1;
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 5'd7;
      req_wdata = 16'h0001;
      req_be    = 2'b11;
      @(negedge clk);
      check("t4_not_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      clr       = 1'b0;
      req_valid = 1'b0;
      count_busy(-1, cnt);
      check("t4_busy_len", 32'(cnt), 32'd32);
      issue(1'b0, 5'd7, 16'h0, 2'b00);
      check("t4_data", 32'(rsp_rdata), 32'hA5A5);

      // 5: async reset with a pending response
      issue(1'b1, 5'd5, 16'h5A5A, 2'b11);
      rsp_ready = 1'b0;
      issue(1'b0, 5'd5, 16'h0, 2'b00);
      check("t5_pending", 32'(rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_valid", 32'(rsp_valid), 32'd0);
      check("t5_async_busy", 32'(busy), 32'd1);
      check("t5_async_rdata", 32'(rsp_rdata), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      count_busy(-1, cnt);
      check("t5_busy_len", 32'(cnt), 32'd32);

      // 6: clr at clr_addr=10 restarts the sequence
      rst_n = 1'b0;
      #2;
      @(posedge clk);
      #1 rst_n = 1'b1;
      count_busy(10, cnt);
      check("t6_busy_len", 32'(cnt), 32'd43);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         clr       = ($urandom_range(0, 299) == 0);
         req_valid = ($urandom_range(0, 3) != 0);
         req_wr    = $urandom_range(0, 1) == 1;
         req_addr  = 5'($urandom_range(0, DEP - 1));
         req_wdata = 16'($urandom);
         req_be    = 2'($urandom_range(0, 3));
         rsp_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      clr       = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      check("end_idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
